// File: rtl/reg_bank_arbiter_if.sv
// Write-request / read bus between four requesters and the register bank arbiter.
// Requesters drive through the master modport; the arbiter serves the slave modport.
interface reg_bank_arbiter_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) ();

  localparam int unsigned NREQ = 4;

  logic [NREQ-1:0]    req;
  logic [NREQ*W-1:0]  wdata;
  logic [NREQ*AW-1:0] waddr;
  logic [AW-1:0]      raddr;
  logic [W-1:0]       rdata;
  logic [NREQ-1:0]    ack;
  logic [1:0]         grant_id;
  logic               busy;

  modport master (
    output req, wdata, waddr, raddr,
    input  rdata, ack, grant_id, busy
  );

  modport slave (
    input  req, wdata, waddr, raddr,
    output rdata, ack, grant_id, busy
  );

endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter for four 4-phase requesters sharing the write port of a
// small register bank; one bank write per granted transaction, combinational read.
module reg_bank_arbiter #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 2
) (
  input  logic             clock,
  input  logic             reset_,
  reg_bank_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            bank_we;

  logic [W-1:0]    bank_q  [NREG];
  logic [W-1:0]    wdata_a [NREQ];
  logic [AW-1:0]   waddr_a [NREQ];

  logic [1:0]      rr_cand;
  logic [1:0]      rr_winner;
  logic            rr_found;

  // Split the packed per-requester write payloads.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      wdata_a[i] = bus.wdata[i*W +: W];
      waddr_a[i] = bus.waddr[i*AW +: AW];
    end
  end

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_q;
    rr_cand   = last_q;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      rr_cand = last_q + 2'(off);
      if (!rr_found && bus.req[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    bank_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_winner;
          busy_d  = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bank_we = 1'b1;
        ack_d   = NREQ'(1) << grant_q;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        // An early req drop lands here too, giving a single-cycle ack.
        if (!bus.req[grant_q]) begin
          ack_d   = '0;
          busy_d  = 1'b0;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Storage bank: written only in the WRITE state, cleared by reset.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        bank_q[r] <= '0;
      end
    end else if (bank_we) begin
      bank_q[waddr_a[grant_q]] <= wdata_a[grant_q];
    end
  end

  assign bus.rdata    = bank_q[bus.raddr];
  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

  ack_onehot0_a: assert property (@(posedge clock) disable iff (!reset_) $onehot0(ack_q));

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed vector table, handshake
// sequences for the multi-cycle corners, and random traffic against a reference model.
module tb_reg_bank_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_v;
  logic [31:0] wdata_v;
  logic [7:0]  waddr_v;
  logic [1:0]  raddr_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.W(W), .AW(AW)) bus ();

  assign bus.req   = req_v;
  assign bus.wdata = wdata_v;
  assign bus.waddr = waddr_v;
  assign bus.raddr = raddr_v;

  reg_bank_arbiter #(.W(W), .AW(AW)) dut (
    .clock  (clk),
    .reset_ (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [3:0]  ack;
    logic [1:0]  gid;
    logic        busy;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [8];

  logic [1:0] grants [8];
  int         n_grants;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // Reference model: one transaction at a time, stepped once per rising edge.
  int m_bank [4];
  int m_last, m_gid, m_ack, m_busy, m_inflight, m_written;

  function automatic void model_reset();
    for (int r = 0; r < 4; r++) m_bank[r] = 0;
    m_last = 3; m_gid = 0; m_ack = 0; m_busy = 0; m_inflight = 0; m_written = 0;
  endfunction

  function automatic void model_step(input logic [3:0] rq, input logic [7:0] wa, input logic [31:0] wd);
    if (m_inflight == 0) begin
      if (rq != 4'd0) begin
        for (int off = 1; off <= 4; off++) begin
          int idx;
          idx = (m_last + off) % 4;
          if (rq[idx]) begin
            m_gid = idx;
            break;
          end
        end
        m_inflight = 1;
        m_written  = 0;
        m_busy     = 1;
      end
    end else if (m_written == 0) begin
      m_bank[int'((wa >> (2 * m_gid)) & 8'd3)] = int'((wd >> (8 * m_gid)) & 32'hFF);
      m_ack     = 1 << m_gid;
      m_written = 1;
    end else if (!rq[m_gid]) begin
      m_ack      = 0;
      m_busy     = 0;
      m_last     = m_gid;
      m_inflight = 0;
    end
  endfunction

  task automatic do_reset();
    req_v = 4'd0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Well-behaved 4-phase requesters in mask; records the first n grants.
  task automatic agent_run(input logic [3:0] mask, input int n);
    int   budget;
    logic prev_busy;
    n_grants  = 0;
    prev_busy = bus.busy;
    budget    = 20 * n;
    for (int i = 0; i < 8; i++) grants[i] = 2'd0;
    req_v = mask;
    while (n_grants < n && budget > 0) begin
      @(posedge clk);
      @(negedge clk);
      budget--;
      check("ack_onehot0", 32'($countones(bus.ack) <= 1), 32'd1);
      if (bus.busy && !prev_busy) begin
        grants[n_grants] = bus.grant_id;
        n_grants++;
      end
      prev_busy = bus.busy;
      for (int i = 0; i < 4; i++) begin
        if (req_v[i] && bus.ack[i]) req_v[i] = 1'b0;
        else if (!req_v[i] && !bus.ack[i] && mask[i]) req_v[i] = 1'b1;
      end
    end
    if (n_grants < n) timeout_fail("agent_run");
    req_v = 4'd0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit found;

    rst_n   = 1'b0;
    req_v   = 4'd0;
    wdata_v = 32'd0;
    waddr_v = 8'd0;
    raddr_v = 2'd0;

    // req, waddr, wdata, raddr | ack, gid, busy, rdata
    vecs[0] = '{4'b0001, 8'h02, 32'h000000A5, 2'd2, 4'b0000, 2'd0, 1'b1, 8'h00};
    vecs[1] = '{4'b0001, 8'h02, 32'h000000A5, 2'd2, 4'b0001, 2'd0, 1'b1, 8'hA5};
    vecs[2] = '{4'b0001, 8'h02, 32'h000000A5, 2'd2, 4'b0001, 2'd0, 1'b1, 8'hA5};
    vecs[3] = '{4'b0000, 8'h02, 32'h000000A5, 2'd2, 4'b0000, 2'd0, 1'b0, 8'hA5};
    vecs[4] = '{4'b0000, 8'h02, 32'h000000A5, 2'd2, 4'b0000, 2'd0, 1'b0, 8'hA5};
    vecs[5] = '{4'b0010, 8'h04, 32'h00003C00, 2'd1, 4'b0000, 2'd1, 1'b1, 8'h00};
    vecs[6] = '{4'b0010, 8'h04, 32'h00003C00, 2'd1, 4'b0010, 2'd1, 1'b1, 8'h3C};
    vecs[7] = '{4'b0000, 8'h04, 32'h00003C00, 2'd1, 4'b0000, 2'd1, 1'b0, 8'h3C};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_gid", 32'(bus.grant_id), 32'd0);
    for (int r = 0; r < 4; r++) begin
      raddr_v = 2'(r);
      #1;
      check("rst_bank", 32'(bus.rdata), 32'd0);
    end

    // Directed vectors: single write, handshake close, read/write collision.
    for (int i = 0; i < 8; i++) begin
      req_v   = vecs[i].req;
      waddr_v = vecs[i].waddr;
      wdata_v = vecs[i].wdata;
      raddr_v = vecs[i].raddr;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), 32'(bus.ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d_gid", i), 32'(bus.grant_id), 32'(vecs[i].gid));
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].rdata));
    end

    // All four requesters held from reset: grants 0,1,2,3,0.
    do_reset();
    waddr_v = 8'hE4;
    wdata_v = 32'h13121110;
    agent_run(4'b1111, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_all_grant%0d", i), 32'(grants[i]), 32'(i % 4));
    for (int r = 0; r < 4; r++) begin
      raddr_v = 2'(r);
      #1;
      check($sformatf("rr_all_bank%0d", r), 32'(bus.rdata), 32'h10 + 32'(r));
    end

    // req0 and req2 pending with last=0: 2 wins, then 0.
    do_reset();
    agent_run(4'b0001, 1);
    check("rr_pre_grant", 32'(grants[0]), 32'd0);
    agent_run(4'b0101, 2);
    check("rr_pair_first", 32'(grants[0]), 32'd2);
    check("rr_pair_second", 32'(grants[1]), 32'd0);

    // Asynchronous reset during ACK of requester 2.
    do_reset();
    waddr_v = 8'h30;
    wdata_v = 32'h005A0000;
    raddr_v = 2'd3;
    req_v   = 4'b0100;
    found   = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.ack == 4'b0100) found = 1'b1;
    end
    if (!found) timeout_fail("arst_wait_ack");
    check("arst_pre_rdata", 32'(bus.rdata), 32'h5A);
    check("arst_pre_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(bus.ack), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk);
    req_v = 4'b1111;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("arst_post_gid", 32'(bus.grant_id), 32'd0);
    check("arst_post_busy", 32'(bus.busy), 32'd1);
    req_v = 4'd0;
    repeat (4) @(negedge clk);

    // Granted requester drops req in the WRITE cycle.
    do_reset();
    waddr_v = 8'h00;
    wdata_v = 32'hC3000000;
    raddr_v = 2'd0;
    req_v   = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    check("early_gid", 32'(bus.grant_id), 32'd3);
    check("early_busy", 32'(bus.busy), 32'd1);
    check("early_ack0", 32'(bus.ack), 32'd0);
    req_v = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("early_ack1", 32'(bus.ack), 32'b1000);
    check("early_rdata", 32'(bus.rdata), 32'hC3);
    @(posedge clk);
    @(negedge clk);
    check("early_ack2", 32'(bus.ack), 32'd0);
    check("early_busy2", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("early_idle", 32'(bus.busy), 32'd0);

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      wdata_v = $urandom;
      waddr_v = 8'($urandom);
      raddr_v = 2'($urandom);
      if ($urandom_range(199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rnd_arst_ack", 32'(bus.ack), 32'd0);
        check("rnd_arst_busy", 32'(bus.busy), 32'd0);
        check("rnd_arst_rdata", 32'(bus.rdata), 32'd0);
      end
      @(posedge clk);
      if (rst_n) model_step(req_v, waddr_v, wdata_v);
      @(negedge clk);
      rst_n = 1'b1;
      check("rnd_ack", 32'(bus.ack), 32'(m_ack));
      check("rnd_busy", 32'(bus.busy), 32'(m_busy));
      check("rnd_gid", 32'(bus.grant_id), 32'(m_gid));
      check("rnd_rdata", 32'(bus.rdata), 32'(m_bank[int'(raddr_v)]));
      for (int i = 0; i < 4; i++) begin
        if (req_v[i] && ((m_ack >> i) & 1) == 1) begin
          if ($urandom_range(3) != 0) req_v[i] = 1'b0;
        end else if (req_v[i] && m_inflight == 1 && m_written == 0 && m_gid == i) begin
          if ($urandom_range(15) == 0) req_v[i] = 1'b0;
        end else if (!req_v[i] && ((m_ack >> i) & 1) == 0) begin
          if ($urandom_range(2) == 0) req_v[i] = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
